scr_lane_gen: RTL and testbench

Parametrised successor to the single-symbol scrambled-data generator for the 100BASE-T1 PCS transmit path. It integrates both side-stream LFSRs (master and slave polynomials) and produces NUM_LANES consecutive 3-bit Sdn symbols per valid cycle. It adds a configurable tx_enable alignment delay line, registered outputs with a valid flag, and zero-state lockup detection and recovery. It sits between the 4B3B/PCS encoder and the PAM3 mapper.

---
 rtl/scr_lane_gen.sv | 105 ++++++++++
 tb/tb_scr_lane_gen.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scr_lane_gen.sv
// 100BASE-T1 PCS side-stream scrambler: NUM_LANES Sdn symbols per word,
// delayed tx_enable, registered outputs and zero-state lockup recovery.
module scr_lane_gen #(
    parameter int          NUM_LANES    = 1,
    parameter int          EN_LEAD      = 3,
    parameter logic [32:0] DEFAULT_SEED = 33'h1_0000_0001
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [32:0]            seed,
    input  logic                   valid,
    input  logic                   master_slave_sw,
    input  logic [1:0]             tx_mode,
    input  logic                   tx_enable,
    input  logic                   loc_rcvr_status,
    input  logic [3*NUM_LANES-1:0] tx_data,
    input  logic                   lockup_clr,
    output logic [3*NUM_LANES-1:0] sdn,
    output logic [NUM_LANES-1:0]   sxn,
    output logic                   out_valid,
    output logic                   lockup_err
);

    localparam int DW = 3 * NUM_LANES;

    function automatic logic [32:0] step(input logic [32:0] s,
                                         input logic sl);
        return {s[31:0], s[32] ^ (sl ? s[19] : s[12])};
    endfunction

    logic [32:0]    lfsr;
    logic [32:0]    st;
    logic [32:0]    lfsr_adv;
    logic [DW-1:0]  sdn_nx;
    logic [NUM_LANES-1:0] sxn_nx;
    logic [2:0]     syn;
    logic [2:0]     scn;
    logic           en_d;
    logic           lock;
    logic           adv;
    logic           set_err;

    if (EN_LEAD == 0) begin : g_nodly
        assign en_d = tx_enable;
    end else begin : g_dly
        logic [EN_LEAD-1:0] dl;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) dl <= '0;
            else        dl <= (dl << 1) | EN_LEAD'(tx_enable);
        end
        assign en_d = dl[EN_LEAD-1];
    end

    // Walk the LFSR once per lane; the final state is the next register value.
    always_comb begin
        st     = lfsr;
        syn    = '0;
        scn    = '0;
        sdn_nx = '0;
        sxn_nx = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            syn = {st[6] ^ st[16], st[3] ^ st[8], st[0]};
            scn = (tx_mode == 2'd0) ? 3'b000 : syn;
            sxn_nx[k] = st[7] ^ st[9] ^ st[12] ^ st[14];
            if (en_d)
                sdn_nx[3*k +: 3] = scn ^ tx_data[3*k +: 3];
            else
                sdn_nx[3*k +: 3] = {scn[2] ^ loc_rcvr_status, scn[1:0]};
            st = step(st, master_slave_sw);
        end
        lfsr_adv = st;
    end

    assign lock    = (lfsr == '0);
    assign adv     = valid && !load && !lock;
    assign set_err = load ? (seed == '0) : lock;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr       <= DEFAULT_SEED;
            sdn        <= '0;
            sxn        <= '0;
            out_valid  <= 1'b0;
            lockup_err <= 1'b0;
        end else begin
            if (load)
                lfsr <= (seed == '0) ? DEFAULT_SEED : seed;
            else if (lock)
                lfsr <= DEFAULT_SEED;
            else if (valid)
                lfsr <= lfsr_adv;
            out_valid <= adv;
            if (adv) begin
                sdn <= sdn_nx;
                sxn <= sxn_nx;
            end
            if (set_err)
                lockup_err <= 1'b1;
            else if (lockup_clr)
                lockup_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_scr_lane_gen.sv
// Directed and model-driven checks for scr_lane_gen with two lanes and a
// three-cycle tx_enable lead.
module tb_scr_lane_gen;

    localparam logic [32:0] DEF = 33'h1_0000_0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [32:0] seed;
    logic        valid;
    logic        ms;
    logic [1:0]  tx_mode;
    logic        tx_enable;
    logic        lrs;
    logic [5:0]  tx_data;
    logic        lockup_clr;
    logic [5:0]  sdn;
    logic [1:0]  sxn;
    logic        out_valid;
    logic        lockup_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [32:0] m_lfsr;
    logic [2:0]  m_dl;
    logic [5:0]  m_sdn;
    logic [1:0]  m_sxn;
    logic        m_ov;
    logic        m_err;

    scr_lane_gen #(
        .NUM_LANES(2),
        .EN_LEAD(3),
        .DEFAULT_SEED(DEF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .load(load),
        .seed(seed),
        .valid(valid),
        .master_slave_sw(ms),
        .tx_mode(tx_mode),
        .tx_enable(tx_enable),
        .loc_rcvr_status(lrs),
        .tx_data(tx_data),
        .lockup_clr(lockup_clr),
        .sdn(sdn),
        .sxn(sxn),
        .out_valid(out_valid),
        .lockup_err(lockup_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] msym(input logic [32:0] s,
                                        input logic e,
                                        input logic [2:0] d);
        logic [2:0] y;
        y = {s[6] ^ s[16], s[3] ^ s[8], s[0]};
        if (tx_mode == 2'd0) y = 3'b000;
        return e ? (y ^ d) : {y[2] ^ lrs, y[1:0]};
    endfunction

    function automatic logic [32:0] mstep(input logic [32:0] s,
                                          input logic sl);
        return {s[31:0], s[32] ^ (sl ? s[19] : s[12])};
    endfunction

    task automatic model_reset();
        m_lfsr = DEF;
        m_dl   = 3'b000;
        m_sdn  = '0;
        m_sxn  = '0;
        m_ov   = 1'b0;
        m_err  = 1'b0;
    endtask

    // Reference behaviour of one rising edge using current inputs.
    task automatic model_edge();
        logic [32:0] s;
        logic        e;
        s    = m_lfsr;
        e    = m_dl[2];
        m_dl = {m_dl[1:0], tx_enable};
        if (load) begin
            m_lfsr = (seed == 0) ? DEF : seed;
            m_ov   = 1'b0;
            if (seed == 0) m_err = 1'b1;
            else if (lockup_clr) m_err = 1'b0;
        end else begin
            if (lockup_clr) m_err = 1'b0;
            m_ov = valid;
            if (valid) begin
                for (int k = 0; k < 2; k++) begin
                    m_sdn[3*k +: 3] = msym(s, e, tx_data[3*k +: 3]);
                    m_sxn[k] = ^(s & 33'h0_0000_5280);
                    s = mstep(s, ms);
                end
                m_lfsr = s;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_sdn"}, 64'(sdn), 64'(m_sdn));
        chk({tag, "_sxn"}, 64'(sxn), 64'(m_sxn));
        chk({tag, "_ov"}, 64'(out_valid), 64'(m_ov));
        chk({tag, "_err"}, 64'(lockup_err), 64'(m_err));
    endtask

    initial begin
        rst_n = 0; load = 0; seed = '0; valid = 0; ms = 0;
        tx_mode = 2'd2; tx_enable = 0; lrs = 0; tx_data = '0;
        lockup_clr = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_sdn", 64'(sdn), 64'h0);
        chk("rst_sxn", 64'(sxn), 64'h0);
        chk("rst_ov", 64'(out_valid), 64'h0);
        chk("rst_err", 64'(lockup_err), 64'h0);
        rst_n = 1;

        // default seed drives the first word, enable still low
        valid = 1;
        step();
        chk("def_sdn", 64'(sdn), 64'(6'b001_001));
        chk("def_ov", 64'(out_valid), 64'h1);
        valid = 0;
        step();
        chk("hold_ov", 64'(out_valid), 64'h0);
        chk("hold_sdn", 64'(sdn), 64'(6'b001_001));

        // seed=1 with enable delayed through
        tx_enable = 1;
        steps(3);
        load = 1; seed = 33'd1;
        step();
        chk("ld_ov", 64'(out_valid), 64'h0);
        load = 0; valid = 1;
        step();
        chk("s1_sdn", 64'(sdn), 64'(6'b000_001));
        chk("s1_sxn", 64'(sxn), 64'h0);
        chk("s1_ov", 64'(out_valid), 64'h1);
        step();
        chk("s4_sdn", 64'(sdn), 64'(6'b010_000));

        tx_mode = 2'd0; tx_data = 6'b101_011;
        step();
        chk("sendz_sdn", 64'(sdn), 64'(6'b101_011));

        // idle path: enable low, receiver status flips Sdn[2]
        tx_mode = 2'd2; tx_data = '0; tx_enable = 0; valid = 0;
        steps(3);
        load = 1; seed = 33'd1; step();
        load = 0; valid = 1; lrs = 1; step();
        chk("idle_lrs1", 64'(sdn), 64'(6'b100_101));
        valid = 0; load = 1; step();
        load = 0; valid = 1; lrs = 0; step();
        chk("idle_lrs0", 64'(sdn), 64'(6'b000_001));
        valid = 0; load = 1; step();
        load = 0; valid = 1; lrs = 1; tx_mode = 2'd0; step();
        chk("idle_sendz", 64'(sdn), 64'(6'b100_100));

        // Sxn tap and polynomial selection
        lrs = 0; tx_mode = 2'd2; tx_enable = 1; valid = 0;
        steps(3);
        load = 1; seed = 33'h80; step();
        load = 0; valid = 1; step();
        chk("sxn_sdn", 64'(sdn), 64'(6'b010_000));
        chk("sxn_sxn", 64'(sxn), 64'(2'b01));
        valid = 0; load = 1; seed = 33'h1_0008_0000; ms = 1; step();
        load = 0; valid = 1; step();
        chk("slave_sdn", 64'(sdn), 64'(6'b000_000));
        valid = 0; load = 1; ms = 0; step();
        load = 0; valid = 1; step();
        chk("master_sdn", 64'(sdn), 64'(6'b001_000));

        // load wins over valid
        load = 1; seed = 33'd1; valid = 1; step();
        chk("ldv_ov", 64'(out_valid), 64'h0);
        chk("ldv_hold", 64'(sdn), 64'(6'b001_000));
        load = 0; step();
        chk("ldv_next", 64'(sdn), 64'(6'b000_001));

        // zero seed and sticky lockup flag
        valid = 0; load = 1; seed = '0; step();
        chk("z_err", 64'(lockup_err), 64'h1);
        chk("z_ov", 64'(out_valid), 64'h0);
        load = 0; valid = 1; step();
        chk("z_sdn", 64'(sdn), 64'(6'b001_001));
        chk("z_err_kept", 64'(lockup_err), 64'h1);
        valid = 0; lockup_clr = 1; step();
        chk("clr_err", 64'(lockup_err), 64'h0);
        load = 1; step();
        chk("setclr_err", 64'(lockup_err), 64'h1);
        load = 0; lockup_clr = 1; step();
        lockup_clr = 0;

        // single enable pulse hits only the word three cycles later
        tx_enable = 0; steps(3);
        tx_data = 6'b111_111; load = 1; seed = 33'd1; step();
        load = 0; valid = 1; tx_enable = 1; step();
        chk_model("p0");
        tx_enable = 0;
        step(); chk_model("p1");
        step(); chk_model("p2");
        step();
        chk("p3_sdn", 64'(sdn), 64'(6'b111_011));
        chk("p3_sxn", 64'(sxn), 64'(2'b10));
        step();
        chk("p4_sdn", 64'(sdn), 64'(6'b000_010));
        chk("p4_sxn", 64'(sxn), 64'(2'b10));

        // long mixed run against the reference model
        for (int i = 0; i < 1000; i++) begin
            valid      = ($urandom_range(0, 3) != 0);
            load       = ($urandom_range(0, 40) == 0);
            seed       = ($urandom_range(0, 3) == 0) ? 33'd0
                         : {1'($urandom), $urandom};
            lockup_clr = ($urandom_range(0, 7) == 0);
            ms         = ($urandom_range(0, 15) == 0) ? ~ms : ms;
            tx_mode    = 2'($urandom);
            tx_enable  = 1'($urandom);
            lrs        = 1'($urandom);
            tx_data    = 6'($urandom);
            step();
            chk_model("rnd");
        end

        // asynchronous reset mid-stream
        load = 0; lockup_clr = 0; valid = 1; tx_enable = 1;
        tx_mode = 2'd2; tx_data = 6'b111_111; lrs = 0;
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_sdn", 64'(sdn), 64'h0);
        chk("arst_sxn", 64'(sxn), 64'h0);
        chk("arst_ov", 64'(out_valid), 64'h0);
        chk("arst_err", 64'(lockup_err), 64'h0);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        step();
        chk("arst_dl_sdn", 64'(sdn), 64'(6'b001_001));
        chk("arst_dl_ov", 64'(out_valid), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
